// File: rtl/ifid_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives the instruction-memory address, and latches the fetched word and its
// PC+4. It also handles the boot bubble, load-use stall, branch/jump redirect and flush bubbles.
// Optional feature: define BRANCH_DELAY_SLOT_EN so that a redirect latches the word being
// fetched (the delay slot) as a valid instruction, instead of inserting a bubble.
module ifid_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] InstrIn,
  output logic [31:0] InstrAddr,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [1:0]  FetchState
);

  typedef enum logic [1:0] {
    StBoot  = 2'b00,
    StRun   = 2'b01,
    StHold  = 2'b10,
    StRedir = 2'b11
  } fetch_state_e;

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect        = BranchTaken | Jump;
  // Branch comes from an older instruction, so it wins over a jump decoded in ID.
  assign redirect_target = BranchTaken ? BranchTarget : JumpTarget;

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: redirect > stall > normal fetch; BOOT always moves on to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot: state_d = StRun;
      default: begin
        if (redirect) begin
          state_d = StRedir;
        end else if (Stall) begin
          state_d = StHold;
        end else begin
          state_d = StRun;
        end
      end
    endcase
  end

  // Datapath next-state: PC and IF/ID contents for the same priority order.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    // BOOT leaves PC and the bubble untouched so InstrIn at RESET_PC can settle.
    if (state_q != StBoot) begin
      if (redirect) begin
        pc_d = {redirect_target[31:2], 2'b00};
`ifdef BRANCH_DELAY_SLOT_EN
        instr_d = InstrIn;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
`else
        instr_d = NOP_WORD;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
`endif
      end else if (!Stall) begin
        pc_d    = {pc_plus4[31:2], 2'b00};
        instr_d = InstrIn;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= NOP_WORD;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  // Outputs: decode fields are plain slices, so a bubble shows OpCode/Funct of NOP_WORD.
  always_comb begin
    InstrAddr        = pc_q;
    IFID_Instruction = instr_q;
    IFID_PCPlus4     = pcp4_q;
    IFID_Valid       = valid_q;
    OpCode           = instr_q[31:26];
    Funct            = instr_q[5:0];
    FetchState       = state_q;
  end

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Bench for ifid_fetch_stage: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model of the fetch rules.
module tb_ifid_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int BOOT = 0, RUN = 1, HOLD = 2, REDIR = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, br = 1'b0, jp = 1'b0;
  logic [31:0] btgt = '0, jtgt = '0;
  logic [31:0] instr_in, instr_addr, ifid_instr, ifid_pcp4;
  logic        ifid_valid;
  logic [5:0]  opcode, funct;
  logic [1:0]  fstate;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pcp4;
  logic        m_valid;
  int          m_st;

  always #5 clk = ~clk;

  // Instruction memory: word[i] = i + 1, read combinationally.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  assign instr_in = mem(instr_addr);

  ifid_fetch_stage dut (
    .Clock           (clk),
    .Reset_n         (rst_n),
    .Stall           (stall),
    .BranchTaken     (br),
    .BranchTarget    (btgt),
    .Jump            (jp),
    .JumpTarget      (jtgt),
    .InstrIn         (instr_in),
    .InstrAddr       (instr_addr),
    .IFID_Instruction(ifid_instr),
    .IFID_PCPlus4    (ifid_pcp4),
    .IFID_Valid      (ifid_valid),
    .OpCode          (opcode),
    .Funct           (funct),
    .FetchState      (fstate)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOP; m_pcp4 = 32'd0; m_valid = 1'b0; m_st = BOOT;
  endtask

  // One rising edge of the fetch rules, using the inputs currently applied.
  task automatic model_clock();
    logic [31:0] tgt;
    if (m_st == BOOT) begin
      m_st = RUN;
    end else if (br || jp) begin
      tgt = br ? btgt : jtgt;
`ifdef BRANCH_DELAY_SLOT_EN
      m_instr = mem(m_pc); m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
`else
      m_instr = NOP; m_pcp4 = 32'd0; m_valid = 1'b0;
`endif
      m_pc = tgt & 32'hFFFF_FFFC;
      m_st = REDIR;
    end else if (stall) begin
      m_st = HOLD;
    end else begin
      m_instr = mem(m_pc); m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      m_st = RUN;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":addr"}, instr_addr, m_pc);
    chk({ctx, ":valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
    chk({ctx, ":instr"}, ifid_instr, m_instr);
    if (m_valid) chk({ctx, ":pcp4"}, ifid_pcp4, m_pcp4);
    chk({ctx, ":opcode"}, {26'd0, opcode}, {26'd0, m_instr[31:26]});
    chk({ctx, ":funct"}, {26'd0, funct}, {26'd0, m_instr[5:0]});
    chk({ctx, ":state"}, {30'd0, fstate}, m_st);
  endtask

  task automatic step(input string ctx, input logic s, input logic b, input logic j,
                      input logic [31:0] bt, input logic [31:0] jt);
    stall = s; br = b; jp = j; btgt = bt; jtgt = jt;
    model_clock();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  // Asynchronous reset pulse landing mid-cycle, then release on the next falling edge.
  task automatic pulse_reset(input string ctx);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Boot bubble, then words 1,2,3.
    step("boot", 1'b1, 1'b1, 1'b1, 32'h80, 32'h40);
    chk("boot_valid", {31'd0, ifid_valid}, 32'd0);
    chk("boot_addr", instr_addr, 32'd0);
    step("f1", 1'b0, 1'b0, 1'b0, 0, 0);
    step("f2", 1'b0, 1'b0, 1'b0, 0, 0);
    step("f3", 1'b0, 1'b0, 1'b0, 0, 0);
    chk("f3_instr", ifid_instr, 32'd3);
    chk("f3_pcp4", ifid_pcp4, 32'd12);

    // Two-cycle stall, then release.
    step("stall1", 1'b1, 1'b0, 1'b0, 0, 0);
    step("stall2", 1'b1, 1'b0, 1'b0, 0, 0);
    chk("stall_instr", ifid_instr, 32'd3);
    chk("stall_addr", instr_addr, 32'd12);
    chk("stall_state", {30'd0, fstate}, 32'd2);
    step("unstall", 1'b0, 1'b0, 1'b0, 0, 0);
    chk("unstall_instr", ifid_instr, 32'd4);

    // Jump to 0x40, then fetch there.
    step("jump", 1'b0, 1'b0, 1'b1, 0, 32'h40);
    chk("jump_addr", instr_addr, 32'h40);
    step("jump_f", 1'b0, 1'b0, 1'b0, 0, 0);
    chk("jump_instr", ifid_instr, mem(32'h40));

    // Branch + jump + stall together: branch wins.
    step("bjs", 1'b1, 1'b1, 1'b1, 32'h80, 32'h40);
    chk("bjs_addr", instr_addr, 32'h80);
    chk("bjs_state", {30'd0, fstate}, 32'd3);
    step("bjs_f", 1'b0, 1'b0, 1'b0, 0, 0);

    // Unaligned target and PC wrap-around.
    step("wrapj", 1'b0, 1'b0, 1'b1, 0, 32'hFFFF_FFFF);
    chk("wrap_addr", instr_addr, 32'hFFFF_FFFC);
    step("wrapf", 1'b0, 1'b0, 1'b0, 0, 0);
    chk("wrap_pcp4", ifid_pcp4, 32'd0);
    chk("wrap_next", instr_addr, 32'd0);

    // Reset during REDIR.
    step("pre_rst", 1'b0, 1'b0, 1'b1, 0, 32'h100);
    pulse_reset("rst_redir");

    // Branch with PC at 12 (branch instruction at 8 sits in IF/ID).
    step("ds_boot", 1'b0, 1'b0, 1'b0, 0, 0);
    step("ds_f1", 1'b0, 1'b0, 1'b0, 0, 0);
    step("ds_f2", 1'b0, 1'b0, 1'b0, 0, 0);
    step("ds_f3", 1'b0, 1'b0, 1'b0, 0, 0);
    step("ds_br", 1'b0, 1'b1, 1'b0, 32'h80, 0);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("ds_slot", ifid_instr, 32'd4);
    chk("ds_slot_valid", {31'd0, ifid_valid}, 32'd1);
`endif
    step("ds_tgt", 1'b0, 1'b0, 1'b0, 0, 0);
    chk("ds_tgt_instr", ifid_instr, mem(32'h80));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        step("rnd", ($urandom_range(4) == 0), ($urandom_range(9) == 0),
             ($urandom_range(9) == 0), $urandom, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
